// File: rtl/cr_timer_ctrl_if.sv
// cr_timer_ctrl_if
// Groups the countdown timer's request, preset and result signals into one bundle.
//
// Signals:
//   load, start, stop, tick          one-cycle requests toward the timer
//   preset_hora/min/seg [7:0]        BCD preset value hh:mm:ss
//   dcr_hora/min/seg [7:0]           BCD current count from the timer
//   en_hora/min/seg                  one-cycle write strobes, one per count field
//   corriendo                        timer is counting down
//   fin_cr                           countdown has finished
//
// Modports:
//   master - sequencer or timebase side (drives the requests, reads the count)
//   slave  - the timer itself
interface cr_timer_ctrl_if;
  logic       load;
  logic       start;
  logic       stop;
  logic       tick;
  logic [7:0] preset_hora;
  logic [7:0] preset_min;
  logic [7:0] preset_seg;
  logic [7:0] dcr_hora;
  logic [7:0] dcr_min;
  logic [7:0] dcr_seg;
  logic       en_hora;
  logic       en_min;
  logic       en_seg;
  logic       corriendo;
  logic       fin_cr;

  modport master (
    output load, start, stop, tick,
    output preset_hora, preset_min, preset_seg,
    input  dcr_hora, dcr_min, dcr_seg,
    input  en_hora, en_min, en_seg,
    input  corriendo, fin_cr
  );

  modport slave (
    input  load, start, stop, tick,
    input  preset_hora, preset_min, preset_seg,
    output dcr_hora, dcr_min, dcr_seg,
    output en_hora, en_min, en_seg,
    output corriendo, fin_cr
  );
endinterface

// File: rtl/cr_timer_ctrl.sv
// cr_timer_ctrl
// BCD hh:mm:ss countdown timer controller. A preset is loaded, counting is
// started and paused on request, and each 1 Hz tick removes one second. Each
// count field comes with a write strobe that is high only in the cycle that
// field takes a new value.
//
// Ports:
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   bus    slave modport of cr_timer_ctrl_if (requests, presets, count, strobes, status)
//
// Parameter:
//   HORA_MAX  highest legal BCD hour; preset hours above it are clamped to it
//
// Build option:
//   CR_AUTORELOAD_EN  when defined, reaching 00:00:00 in RUN pulses fin_cr for
//                     one cycle and stays in RUN; the next tick reloads the last
//                     clamped preset. When undefined, reaching zero enters DONE.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | holding a count (loaded or reset); waits for start
// ST_RUN   | counting down, one second per tick
// ST_PAUSE | count held after stop; start resumes
// ST_DONE  | count reached zero; only load leaves this state
module cr_timer_ctrl #(
  parameter logic [7:0] HORA_MAX = 8'h23
) (
  input  logic            clk,
  input  logic            rst_n,
  cr_timer_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t     r_state;
  logic [7:0] r_hora;
  logic [7:0] r_min;
  logic [7:0] r_seg;
  logic [2:0] r_en;
  logic       r_corriendo;
  logic       r_fin_cr;

  state_t     w_nxt_state;
  logic [7:0] w_nxt_hora;
  logic [7:0] w_nxt_min;
  logic [7:0] w_nxt_seg;
  logic [2:0] w_nxt_en;
  logic       w_fin_pulse;

  logic [7:0] w_clamp_hora;
  logic [7:0] w_clamp_min;
  logic [7:0] w_clamp_seg;
  logic [7:0] w_dec_hora;
  logic [7:0] w_dec_min;
  logic [7:0] w_dec_seg;
  logic       w_borrow_min;
  logic       w_borrow_hora;
  logic       w_cnt_zero;
  logic       w_dec_zero;

`ifdef CR_AUTORELOAD_EN
  logic [7:0] r_pre_hora;
  logic [7:0] r_pre_min;
  logic [7:0] r_pre_seg;
  logic [7:0] w_nxt_pre_hora;
  logic [7:0] w_nxt_pre_min;
  logic [7:0] w_nxt_pre_seg;
  logic       w_pre_zero;
`endif

  // A value above the limit saturates to the limit. Otherwise the tens digit is
  // already legal, and only the units digit can still be a non-decimal nibble.
  function automatic logic [7:0] clamp_bcd(input logic [7:0] v, input logic [7:0] lim);
    logic [3:0] lo;
    if (v > lim) begin
      return lim;
    end
    lo = (v[3:0] > 4'd9) ? 4'd9 : v[3:0];
    return {v[7:4], lo};
  endfunction

  // Two-digit BCD decrement. 00 wraps to wrap_val, which is the borrow case.
  function automatic logic [7:0] dec_bcd(input logic [7:0] v, input logic [7:0] wrap_val);
    if (v == 8'h00) begin
      return wrap_val;
    end
    if (v[3:0] == 4'd0) begin
      return {v[7:4] - 4'd1, 4'd9};
    end
    return {v[7:4], v[3:0] - 4'd1};
  endfunction

  assign w_clamp_hora = clamp_bcd(bus.preset_hora, HORA_MAX);
  assign w_clamp_min  = clamp_bcd(bus.preset_min, 8'h59);
  assign w_clamp_seg  = clamp_bcd(bus.preset_seg, 8'h59);

  // Seconds always change on a decrement. Minutes and hours change only on a
  // borrow. A borrow out of the hours field cannot occur, because a zero count
  // never decrements.
  assign w_borrow_min  = (r_seg == 8'h00);
  assign w_borrow_hora = w_borrow_min && (r_min == 8'h00);
  assign w_dec_seg     = dec_bcd(r_seg, 8'h59);
  assign w_dec_min     = w_borrow_min  ? dec_bcd(r_min, 8'h59) : r_min;
  assign w_dec_hora    = w_borrow_hora ? dec_bcd(r_hora, HORA_MAX) : r_hora;

  assign w_cnt_zero = (r_hora == 8'h00) && (r_min == 8'h00) && (r_seg == 8'h00);
  assign w_dec_zero = (w_dec_hora == 8'h00) && (w_dec_min == 8'h00) && (w_dec_seg == 8'h00);

`ifdef CR_AUTORELOAD_EN
  assign w_pre_zero = (r_pre_hora == 8'h00) && (r_pre_min == 8'h00) && (r_pre_seg == 8'h00);
`endif

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_hora  = r_hora;
    w_nxt_min   = r_min;
    w_nxt_seg   = r_seg;
    w_nxt_en    = 3'b000;
    w_fin_pulse = 1'b0;
`ifdef CR_AUTORELOAD_EN
    w_nxt_pre_hora = r_pre_hora;
    w_nxt_pre_min  = r_pre_min;
    w_nxt_pre_seg  = r_pre_seg;
`endif
    case (r_state)
      ST_RUN: begin
        if (bus.tick) begin
`ifdef CR_AUTORELOAD_EN
          // A tick at zero count reloads the preset instead of decrementing.
          if (w_cnt_zero) begin
            if (w_pre_zero) begin
              w_nxt_state = ST_DONE;
            end else begin
              w_nxt_hora = r_pre_hora;
              w_nxt_min  = r_pre_min;
              w_nxt_seg  = r_pre_seg;
              w_nxt_en   = 3'b111;
            end
          end else begin
`endif
            w_nxt_hora = w_dec_hora;
            w_nxt_min  = w_dec_min;
            w_nxt_seg  = w_dec_seg;
            w_nxt_en   = {w_borrow_hora, w_borrow_min, 1'b1};
            if (w_dec_zero) begin
`ifdef CR_AUTORELOAD_EN
              w_fin_pulse = 1'b1;
`else
              w_nxt_state = ST_DONE;
`endif
            end
`ifdef CR_AUTORELOAD_EN
          end
`endif
        end
        // A stop in the same cycle as a tick still lets the decrement through.
        // Reaching DONE takes priority over the pause.
        if (bus.stop && (w_nxt_state == ST_RUN)) begin
          w_nxt_state = ST_PAUSE;
        end
      end
      default: begin
        // ST_IDLE, ST_PAUSE and ST_DONE. Load takes priority over start, and
        // a stop in the same cycle cancels a start.
        if (bus.load) begin
          w_nxt_hora  = w_clamp_hora;
          w_nxt_min   = w_clamp_min;
          w_nxt_seg   = w_clamp_seg;
          w_nxt_en    = 3'b111;
          w_nxt_state = ST_IDLE;
`ifdef CR_AUTORELOAD_EN
          w_nxt_pre_hora = w_clamp_hora;
          w_nxt_pre_min  = w_clamp_min;
          w_nxt_pre_seg  = w_clamp_seg;
`endif
        end else if ((r_state != ST_DONE) && bus.start && !bus.stop && !w_cnt_zero) begin
          w_nxt_state = ST_RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_hora      <= 8'h00;
      r_min       <= 8'h00;
      r_seg       <= 8'h00;
      r_en        <= 3'b000;
      r_corriendo <= 1'b0;
      r_fin_cr    <= 1'b0;
`ifdef CR_AUTORELOAD_EN
      r_pre_hora  <= 8'h00;
      r_pre_min   <= 8'h00;
      r_pre_seg   <= 8'h00;
`endif
    end else begin
      r_state     <= w_nxt_state;
      r_hora      <= w_nxt_hora;
      r_min       <= w_nxt_min;
      r_seg       <= w_nxt_seg;
      r_en        <= w_nxt_en;
      r_corriendo <= (w_nxt_state == ST_RUN);
      r_fin_cr    <= (w_nxt_state == ST_DONE) || w_fin_pulse;
`ifdef CR_AUTORELOAD_EN
      r_pre_hora  <= w_nxt_pre_hora;
      r_pre_min   <= w_nxt_pre_min;
      r_pre_seg   <= w_nxt_pre_seg;
`endif
    end
  end

  assign bus.dcr_hora  = r_hora;
  assign bus.dcr_min   = r_min;
  assign bus.dcr_seg   = r_seg;
  assign bus.en_hora   = r_en[2];
  assign bus.en_min    = r_en[1];
  assign bus.en_seg    = r_en[0];
  assign bus.corriendo = r_corriendo;
  assign bus.fin_cr    = r_fin_cr;

endmodule

// File: tb/tb_cr_timer_ctrl.sv
// tb_cr_timer_ctrl
// Directed bench for cr_timer_ctrl. A reference model keeps the count as total
// seconds and derives the BCD fields and strobes from that total. It is
// compared with the DUT on every falling clock edge. Hand-computed literal
// checks fix known points of the sequence.
module tb_cr_timer_ctrl;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  cr_timer_ctrl_if bus();

  cr_timer_ctrl #(.HORA_MAX(8'h23)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

`ifdef CR_AUTORELOAD_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  localparam int S_IDLE  = 0;
  localparam int S_RUN   = 1;
  localparam int S_PAUSE = 2;
  localparam int S_DONE  = 3;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  int         m_st    = S_IDLE;
  int         m_sec   = 0;
  int         m_pre   = 0;
  int         m_old   = 0;
  logic [2:0] m_en    = 3'b000;
  bit         m_pulse = 1'b0;

  function automatic logic [7:0] to_bcd(input int v);
    return 8'((v / 10) * 16 + (v % 10));
  endfunction

  function automatic logic [7:0] f_hh(input int s);
    return to_bcd(s / 3600);
  endfunction

  function automatic logic [7:0] f_mm(input int s);
    return to_bcd((s / 60) % 60);
  endfunction

  function automatic logic [7:0] f_ss(input int s);
    return to_bcd(s % 60);
  endfunction

  // Converts each BCD digit to decimal (non-decimal digits become 9), then
  // limits the result.
  function automatic int preset_val(input logic [7:0] v, input int lim);
    int hi;
    int lo;
    int d;
    hi = int'(v[7:4]);
    lo = int'(v[3:0]);
    if (hi > 9) hi = 9;
    if (lo > 9) lo = 9;
    d = hi * 10 + lo;
    return (d > lim) ? lim : d;
  endfunction

  // Reference model, one update per clock.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_st = S_IDLE; m_sec = 0; m_pre = 0; m_en = 3'b000; m_pulse = 1'b0;
    end else begin
      m_en = 3'b000;
      m_pulse = 1'b0;
      if (m_st == S_RUN) begin
        if (bus.tick) begin
          if (m_sec == 0) begin
            if (m_pre == 0) m_st = S_DONE;
            else begin
              m_sec = m_pre;
              m_en = 3'b111;
            end
          end else begin
            m_old = m_sec;
            m_sec = m_sec - 1;
            m_en = {f_hh(m_old) != f_hh(m_sec), f_mm(m_old) != f_mm(m_sec), f_ss(m_old) != f_ss(m_sec)};
            if (m_sec == 0) begin
              if (AR) m_pulse = 1'b1;
              else m_st = S_DONE;
            end
          end
        end
        if (m_st == S_RUN && bus.stop) m_st = S_PAUSE;
      end else if (bus.load) begin
        m_sec = preset_val(bus.preset_hora, 23) * 3600 + preset_val(bus.preset_min, 59) * 60 +
                preset_val(bus.preset_seg, 59);
        m_pre = m_sec;
        m_en = 3'b111;
        m_st = S_IDLE;
      end else if (m_st != S_DONE && bus.start && !bus.stop && m_sec != 0) begin
        m_st = S_RUN;
      end
    end
  end

  // Per-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      n_vec++;
      if ({bus.dcr_hora, bus.dcr_min, bus.dcr_seg, bus.en_hora, bus.en_min, bus.en_seg, bus.corriendo, bus.fin_cr}
          !== {f_hh(m_sec), f_mm(m_sec), f_ss(m_sec), m_en, (m_st == S_RUN), ((m_st == S_DONE) || m_pulse)}) begin
        n_err++;
        $display("FAIL model_cycle t=%0t: got %h:%h:%h en=%b%b%b run=%b fin=%b, want %h:%h:%h en=%b run=%b fin=%b",
                 $time, bus.dcr_hora, bus.dcr_min, bus.dcr_seg, bus.en_hora, bus.en_min, bus.en_seg,
                 bus.corriendo, bus.fin_cr, f_hh(m_sec), f_mm(m_sec), f_ss(m_sec), m_en,
                 (m_st == S_RUN), ((m_st == S_DONE) || m_pulse));
      end
    end
  end

  task automatic check_now(input string name, input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                           input logic [2:0] en, input logic run, input logic fin);
    n_vec++;
    if ({bus.dcr_hora, bus.dcr_min, bus.dcr_seg, bus.en_hora, bus.en_min, bus.en_seg, bus.corriendo, bus.fin_cr}
        !== {h, m, s, en, run, fin}) begin
      n_err++;
      $display("FAIL %s: got %h:%h:%h en=%b%b%b run=%b fin=%b, want %h:%h:%h en=%b run=%b fin=%b",
               name, bus.dcr_hora, bus.dcr_min, bus.dcr_seg, bus.en_hora, bus.en_min, bus.en_seg,
               bus.corriendo, bus.fin_cr, h, m, s, en, run, fin);
    end
  endtask

  task automatic lit(input string name, input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                     input logic [2:0] en, input logic run, input logic fin);
    @(negedge clk);
    #1;
    check_now(name, h, m, s, en, run, fin);
  endtask

  // Applies one cycle of requests, then returns all requests to zero.
  task automatic drive(input bit ld, input bit st, input bit sp, input bit tk,
                       input logic [7:0] ph = 8'h00, input logic [7:0] pm = 8'h00, input logic [7:0] ps = 8'h00);
    bus.load = ld; bus.start = st; bus.stop = sp; bus.tick = tk;
    bus.preset_hora = ph; bus.preset_min = pm; bus.preset_seg = ps;
    @(posedge clk);
    #1;
    bus.load = 1'b0; bus.start = 1'b0; bus.stop = 1'b0; bus.tick = 1'b0;
  endtask

  task automatic do_load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    drive(1'b1, 1'b0, 1'b0, 1'b0, h, m, s);
  endtask
  task automatic do_start(); drive(1'b0, 1'b1, 1'b0, 1'b0); endtask
  task automatic do_stop();  drive(1'b0, 1'b0, 1'b1, 1'b0); endtask
  task automatic do_tick();  drive(1'b0, 1'b0, 1'b0, 1'b1); endtask

  initial begin
    bus.load = 1'b0; bus.start = 1'b0; bus.stop = 1'b0; bus.tick = 1'b0;
    bus.preset_hora = 8'h00; bus.preset_min = 8'h00; bus.preset_seg = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b1;
    check_now("reset_state", 8'h00, 8'h00, 8'h00, 3'b000, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    do_start();
    lit("start_zero_ignored", 8'h00, 8'h00, 8'h00, 3'b000, 1'b0, 1'b0);
    do_load(8'h01, 8'h00, 8'h00);
    lit("load_010000", 8'h01, 8'h00, 8'h00, 3'b111, 1'b0, 1'b0);
    do_start();
    lit("start_run", 8'h01, 8'h00, 8'h00, 3'b000, 1'b1, 1'b0);
    do_tick();
    lit("tick_borrow_all", 8'h00, 8'h59, 8'h59, 3'b111, 1'b1, 1'b0);
    lit("strobe_one_cycle", 8'h00, 8'h59, 8'h59, 3'b000, 1'b1, 1'b0);
    do_stop();
    lit("stop_pause", 8'h00, 8'h59, 8'h59, 3'b000, 1'b0, 1'b0);
    do_tick();
    lit("tick_in_pause", 8'h00, 8'h59, 8'h59, 3'b000, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    lit("start_stop_pause", 8'h00, 8'h59, 8'h59, 3'b000, 1'b0, 1'b0);
    do_start();
    lit("resume", 8'h00, 8'h59, 8'h59, 3'b000, 1'b1, 1'b0);
    do_load(8'h11, 8'h11, 8'h11);
    lit("load_in_run", 8'h00, 8'h59, 8'h59, 3'b000, 1'b1, 1'b0);
    do_tick();
    lit("tick_seg_only", 8'h00, 8'h59, 8'h58, 3'b001, 1'b1, 1'b0);

    do_stop();
    do_load(8'h00, 8'h00, 8'h02);
    lit("load_000002", 8'h00, 8'h00, 8'h02, 3'b111, 1'b0, 1'b0);
    do_start();
    do_tick();
    lit("tick_to_01", 8'h00, 8'h00, 8'h01, 3'b001, 1'b1, 1'b0);
    do_tick();
`ifdef CR_AUTORELOAD_EN
    lit("zero_pulse", 8'h00, 8'h00, 8'h00, 3'b001, 1'b1, 1'b1);
    lit("pulse_end", 8'h00, 8'h00, 8'h00, 3'b000, 1'b1, 1'b0);
    do_tick();
    lit("autoreload", 8'h00, 8'h00, 8'h02, 3'b111, 1'b1, 1'b0);
    do_load(8'h00, 8'h00, 8'h01);
    do_stop();
    do_load(8'h00, 8'h00, 8'h01);
    do_start();
    do_tick();
    lit("ar_zero", 8'h00, 8'h00, 8'h00, 3'b001, 1'b1, 1'b1);
    do_tick();
    lit("ar_reload_01", 8'h00, 8'h00, 8'h01, 3'b111, 1'b1, 1'b0);
    do_stop();
    do_load(8'h00, 8'h01, 8'h00);
`else
    lit("zero_done", 8'h00, 8'h00, 8'h00, 3'b001, 1'b0, 1'b1);
    do_tick();
    do_start();
    lit("done_holds", 8'h00, 8'h00, 8'h00, 3'b000, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h01, 8'h00);
`endif
    lit("load_wins", 8'h00, 8'h01, 8'h00, 3'b111, 1'b0, 1'b0);
    do_start();
    do_tick();
    lit("min_borrow", 8'h00, 8'h00, 8'h59, 3'b011, 1'b1, 1'b0);

    do_stop();
    do_load(8'h25, 8'h7A, 8'h61);
    lit("clamp_25_7A_61", 8'h23, 8'h59, 8'h59, 3'b111, 1'b0, 1'b0);
    do_load(8'h3F, 8'h0F, 8'hA9);
    lit("clamp_3F_0F_A9", 8'h23, 8'h09, 8'h59, 3'b111, 1'b0, 1'b0);
    do_load(8'h10, 8'h00, 8'h00);
    do_start();
    do_tick();
    lit("hour_digit_borrow", 8'h09, 8'h59, 8'h59, 3'b111, 1'b1, 1'b0);
    do_stop();
    do_load(8'h00, 8'h20, 8'h00);
    do_start();
    do_tick();
    lit("min_digit_borrow", 8'h00, 8'h19, 8'h59, 3'b011, 1'b1, 1'b0);

    do_stop();
    do_load(8'h00, 8'h10, 8'h05);
    do_start();
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    lit("tick_stop", 8'h00, 8'h10, 8'h04, 3'b001, 1'b0, 1'b0);
    do_tick();
    do_tick();
    lit("paused_ticks", 8'h00, 8'h10, 8'h04, 3'b000, 1'b0, 1'b0);
    do_start();
    lit("restart", 8'h00, 8'h10, 8'h04, 3'b000, 1'b1, 1'b0);

    do_stop();
    do_load(8'h12, 8'h34, 8'h56);
    do_start();
    lit("run_123456", 8'h12, 8'h34, 8'h56, 3'b000, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_now("async_reset", 8'h00, 8'h00, 8'h00, 3'b000, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    lit("after_release", 8'h00, 8'h00, 8'h00, 3'b000, 1'b0, 1'b0);
    do_tick();
    lit("tick_in_idle", 8'h00, 8'h00, 8'h00, 3'b000, 1'b0, 1'b0);
    do_start();
    lit("start_zero_again", 8'h00, 8'h00, 8'h00, 3'b000, 1'b0, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cr_timer_ctrl.md
CR_TIMER_CTRL -- requirements
Module: cr_timer_ctrl

Interface
REQ-001 Parameter HORA_MAX, 8'h23, highest legal BCD hour value; preset hours above it are clamped to it.
REQ-002 clk  in  1  single system clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset; clears all state immediately when 0.
REQ-004 load  in  1  one-cycle request to copy preset_* into the count.
REQ-005 start  in  1  one-cycle request to begin or resume counting down.
REQ-006 stop  in  1  one-cycle request to pause counting.
REQ-007 tick  in  1  one-cycle 1 Hz enable from the timebase.
REQ-008 preset_hora / preset_min / preset_seg  in  8 each  BCD preset values (hh, mm, ss).
REQ-009 dcr_hora / dcr_min / dcr_seg  out  8 each  registered BCD current count, feeding the downstream hour/minute/second holding registers.
REQ-010 en_hora / en_min / en_seg  out  1 each  one-cycle write strobe; high exactly in the cycle the matching dcr_* carries a new value.
REQ-011 corriendo  out  1  high while in RUN.
REQ-012 fin_cr  out  1  high while in DONE.

Function
REQ-013 FSM states: IDLE, RUN, PAUSE, DONE; all outputs registered.
REQ-014 load in IDLE/PAUSE/DONE: clamp preset (hora>HORA_MAX -> HORA_MAX; min/seg >8'h59 -> 8'h59; any nibble >9 -> 9); new values on dcr_* next cycle with all three en_* high; next state IDLE.
REQ-015 load in RUN: ignored.
REQ-016 start in IDLE or PAUSE with count != 00:00:00: RUN next cycle; with zero count: ignored.
REQ-017 start in DONE: ignored; only load leaves DONE.
REQ-018 stop in RUN: PAUSE next cycle; count held; stop in other states ignored.
REQ-019 tick in RUN: decrement one second in BCD; ss 00 -> 59 with borrow to mm; mm 00 -> 59 with borrow to hh; result valid the following cycle.
REQ-020 Strobe rule: en_x high only for the field(s) whose value changed on that tick (e.g. 01:00:00 -> 00:59:59 strobes all three; 00:10:05 -> 00:10:04 strobes en_seg only).
REQ-021 When a decrement yields 00:00:00, next state is DONE (fin_cr high, corriendo low) in the same cycle the zero values and strobes appear.
REQ-022 tick outside RUN: ignored.
REQ-023 Simultaneous tick+stop in RUN: decrement applied, then PAUSE.
REQ-024 Simultaneous start+stop: stop wins (RUN -> PAUSE; IDLE/PAUSE unchanged).
REQ-025 Simultaneous load+start in IDLE/PAUSE/DONE: load wins, start discarded.
REQ-026 en_* never high for more than one consecutive cycle without a new load or tick.

Reset
REQ-027 reset low: state IDLE, dcr_* = 8'h00, en_* = 0, corriendo = 0, fin_cr = 0, stored preset = 00:00:00, asynchronously, including mid-count.
REQ-028 After reset release, first active edge behaves as from IDLE; no strobe is generated by reset itself.

Configuration
REQ-029 Macro CR_AUTORELOAD_EN defined: on reaching 00:00:00 in RUN, fin_cr pulses one cycle, state stays RUN, and the next tick loads the last clamped preset (all en_* high) instead of decrementing; a zero preset goes to DONE as normal.
REQ-030 CR_AUTORELOAD_EN undefined: reaching zero enters DONE per REQ-021; stored preset register may be omitted.

Verification
REQ-031 Load 01:00:00, start, one tick -> dcr = 00:59:59, en_hora/en_min/en_seg all high one cycle, corriendo=1.
REQ-032 Load 00:00:02, start, two ticks -> 00:00:01 then 00:00:00, fin_cr=1, corriendo=0; further tick/start no change.
REQ-033 Load preset 8'h25:8'h7A:8'h61 -> dcr = 23:59:59 with all strobes high.
REQ-034 RUN at 00:10:05, tick+stop same cycle -> 00:10:04, en_seg only, state PAUSE; later ticks ignored until start.
REQ-035 Reset asserted low mid-RUN at 12:34:56 -> all outputs zero immediately, IDLE after release, no strobes.
REQ-036 With CR_AUTORELOAD_EN, load 00:00:01, start, two ticks -> 00:00:00 with fin_cr one-cycle pulse, then 00:00:01 with all strobes, still RUN.
